// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared widths, Q4.12 constants and datapath types for the
//               bit-serial synapse multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int FRAC_DEF  = 12;

    // Q4.12 reference values
    localparam logic [WIDTH_DEF-1:0] Q_ONE = 16'h1000;
    localparam logic [WIDTH_DEF-1:0] Q_MAX = 16'h7FFF;
    localparam logic [WIDTH_DEF-1:0] Q_MIN = 16'h8000;

    typedef logic signed [WIDTH_DEF-1:0]   q_t;
    typedef logic signed [2*WIDTH_DEF-1:0] acc_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_qsat.sv
`default_nettype none
// ============================================================================
// Module      : mult_qsat
// Description : Extracts the fixed-point result window from the double-width
//               accumulator (floor rounding). When MULT_SAT_EN is defined,
//               out-of-range results clamp to the most positive / most
//               negative code; otherwise the high bits simply wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_qsat
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic signed [2*WIDTH-1:0] acc,
    output logic signed [WIDTH-1:0]   q
);

    // Dropping the low FRAC bits of a two's-complement value is a floor.
    logic [WIDTH-1:0] w_trunc;
    assign w_trunc = acc[FRAC+WIDTH-1:FRAC];

`ifdef MULT_SAT_EN
    // Bits above the window plus the window's sign bit must all agree for
    // the value to be representable.
    logic [2*WIDTH-1-(FRAC+WIDTH-1):0] w_hi;
    logic                              w_ovf;
    logic                              w_unused;

    assign w_hi     = acc[2*WIDTH-1:FRAC+WIDTH-1];
    assign w_ovf    = !((&w_hi) || !(|w_hi));
    assign w_unused = ^acc[FRAC-1:0];

    // Clamp toward the sign of the true result on overflow.
    always_comb begin
        q = w_trunc;
        if (w_ovf) begin
            q = acc[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{acc[2*WIDTH-1:FRAC+WIDTH], acc[FRAC-1:0]};
    assign q        = w_trunc;
`endif

endmodule : mult_qsat
`default_nettype wire

// File: rtl/bit_serial_mult.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_mult
// Description : Bit-serial signed fixed-point multiplier. A parallel neuron
//               operand is multiplied by a weight streamed LSB first, one bit
//               per enabled clock; the product is registered after WIDTH
//               enabled edges. Optional macro MULT_SAT_EN selects saturating
//               result extraction instead of wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] input_neuron,
    input  logic                    Weight_bit,
    input  logic                    enable,
    output logic signed [WIDTH-1:0] out
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0]          r_cnt;
    logic signed [WIDTH-1:0]   r_operand;
    logic signed [2*WIDTH-1:0] r_acc;
    logic signed [WIDTH-1:0]   r_out;

    logic                      w_first;
    logic                      w_last;
    logic signed [WIDTH-1:0]   w_operand;
    logic signed [2*WIDTH-1:0] w_base;
    logic signed [2*WIDTH-1:0] w_term;
    logic signed [2*WIDTH-1:0] w_acc_next;
    logic signed [WIDTH-1:0]   w_q;

    assign w_first   = (r_cnt == '0);
    assign w_last    = (r_cnt == LAST_BIT);

    // Bit 0 uses the live input (it is being latched on this same edge) and
    // starts from a clean accumulator, so no idle cycle is needed between words.
    assign w_operand = w_first ? input_neuron : r_operand;
    assign w_base    = w_first ? '0 : r_acc;
    assign w_term    = {{WIDTH{w_operand[WIDTH-1]}}, w_operand} << r_cnt;

    // Partial-product step: the weight's MSB carries negative weight.
    always_comb begin
        w_acc_next = w_base;
        if (Weight_bit) begin
            w_acc_next = w_last ? (w_base - w_term) : (w_base + w_term);
        end
    end

    mult_qsat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_qsat (
        .acc (w_acc_next),
        .q   (w_q)
    );

    // Datapath state advances only on enabled edges; result loads on the last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_out     <= '0;
        end else if (enable) begin
            r_acc <= w_acc_next;
            if (w_first) begin
                r_operand <= input_neuron;
            end
            if (w_last) begin
                r_out <= w_q;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out = r_out;

endmodule : bit_serial_mult
`default_nettype wire

// File: tb/tb_bit_serial_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_mult
// Description : Scoreboard bench for bit_serial_mult. The driver pushes the
//               hand-computed product of each word when it starts; a monitor
//               counts enabled edges, pops and compares on every completion
//               edge, and checks that out holds on all other edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_mult;
    import mult_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] input_neuron;
    logic        Weight_bit;
    logic        enable;
    logic [15:0] out;

    logic [15:0] exp_q[$];
    logic [15:0] last_exp;
    int          mcnt;
    int          n_chk;
    int          n_pass;

    bit_serial_mult dut (
        .clk          (clk),
        .reset        (reset),
        .input_neuron (input_neuron),
        .Weight_bit   (Weight_bit),
        .enable       (enable),
        .out          (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: out=%h expected=%h at t=%0t", name, act, req, $time);
    endtask

    // Monitor: mirrors the enabled-edge count to know when a product is due.
    always @(posedge clk) begin
        if (reset) begin
            mcnt     = 0;
            last_exp = 16'h0000;
        end else if (enable && mcnt == 15) begin
            mcnt = 0;
            #1;
            if (exp_q.size() == 0) begin
                check("unexpected_completion", out, last_exp);
                n_chk++;
                $display("FAIL scoreboard_empty: completion with no expected word");
            end else begin
                last_exp = exp_q.pop_front();
                check("product", out, last_exp);
            end
        end else begin
            if (enable) mcnt++;
            #1;
            check("hold", out, last_exp);
        end
    end

    // Drive one weight word LSB first; optional stall or reset abort.
    task automatic send_word(input logic [15:0] a, input logic [15:0] w, input logic [15:0] e,
                             input int stall_at, input int stall_n, input int abort_at);
        if (abort_at < 0) exp_q.push_back(e);
        for (int b = 0; b < 16; b++) begin
            if (b == abort_at) begin
                @(negedge clk);
                reset = 1'b1;
                #1 check("reset_async", out, 16'h0000);
                repeat (2) begin
                    @(negedge clk);
                    check("reset_hold", out, 16'h0000);
                end
                reset  = 1'b0;
                enable = 1'b0;
                return;
            end
            if (b == stall_at) begin
                repeat (stall_n) begin
                    @(negedge clk);
                    enable       = 1'b0;
                    Weight_bit   = ~w[b];
                    input_neuron = ~a;
                end
            end
            @(negedge clk);
            enable       = 1'b1;
            Weight_bit   = w[b];
            // Scramble the operand after bit 0: the latched copy must be used.
            input_neuron = (b == 0) ? a : (a ^ 16'h5A5A);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable     = 1'b0;
            Weight_bit = 1'b0;
        end
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        mcnt         = 0;
        last_exp     = 16'h0000;
        reset        = 1'b1;
        enable       = 1'b0;
        Weight_bit   = 1'b0;
        input_neuron = Q_ONE;

        // Reset held while inputs toggle: out must stay zero.
        repeat (2) begin
            @(negedge clk);
            enable     = ~enable;
            Weight_bit = ~Weight_bit;
            #1 check("reset_state", out, 16'h0000);
        end
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        idle(2);

        send_word(16'h1000, 16'h0001, 16'h0001, -1, 0, -1);  // 1.0 x 2^-12
        idle(2);
        send_word(16'h1000, 16'h2000, 16'h2000, -1, 0, -1);  // 1.0 x 2.0
        idle(1);
        send_word(16'h1000, 16'hF000, 16'hF000, -1, 0, -1);  // 1.0 x -1.0
        idle(1);
        send_word(16'hE000, 16'hE000, 16'h4000, -1, 0, -1);  // -2.0 x -2.0
        idle(1);
        send_word(16'hFFFF, 16'h0001, 16'hFFFF, -1, 0, -1);  // -1 LSB x 1 LSB: floor
        idle(1);
        send_word(16'h1000, 16'h2000, 16'h2000, 6, 3, -1);   // stall 3 cycles after bit 5
        idle(1);
`ifdef MULT_SAT_EN
        send_word(16'h7FFF, 16'h7FFF, 16'h7FFF, -1, 0, -1);
        idle(1);
        send_word(16'h8000, 16'h7FFF, 16'h8000, -1, 0, -1);
`else
        send_word(16'h7FFF, 16'h7FFF, 16'hFFF0, -1, 0, -1);
        idle(1);
        send_word(16'h8000, 16'h7FFF, 16'h0008, -1, 0, -1);
`endif
        idle(1);
        send_word(16'h1000, 16'h0001, 16'h0000, -1, 0, 8);   // aborted by reset at bit 8
        idle(1);
        send_word(16'h1000, 16'h0001, 16'h0001, -1, 0, -1);  // back-to-back pair
        send_word(16'hE000, 16'hE000, 16'h4000, -1, 0, -1);
        idle(4);

        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d words outstanding, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_bit_serial_mult
`default_nettype wire
